// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration loader.
// State encoding, tile module ids and the default "no tile decodes this" address.
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    GET_ADDR,
    GET_DATA,
    WRITE,
    CHECK,
    DONE
  } state_t;

  localparam logic [15:0] MOD_CLB = 16'd4;
  localparam logic [15:0] MOD_CB1 = 16'd5;
  localparam logic [15:0] MOD_CB0 = 16'd6;
  localparam logic [15:0] MOD_SB  = 16'd7;

  localparam logic [31:0] DEFAULT_IDLE_ADDR = 32'hFFFF_FFFF;

  // Saturating increment for the write counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/config_loader_xor_accum.sv
// 32-bit XOR accumulator used to verify the trailing checksum word.
// Only instantiated when CONFIG_LOADER_CHECKSUM_EN is defined.
module config_xor_accum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] acc
);

  logic [31:0] acc_q, acc_d;

  // Clear has priority so a new load never inherits the previous sum.
  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q ^ din;
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/config_loader.sv
// Bitstream-to-broadcast configuration loader for the PE tile array.
// Stream: N, then N {addr, data} pairs; each pair becomes a held write on config_addr/data.
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN adds a trailing XOR checksum word.
//
// state    | meaning
// IDLE     | waiting for start
// HEADER   | accepting write count N
// GET_ADDR | accepting pair address
// GET_DATA | accepting pair data
// WRITE    | holding addr/data on the broadcast bus
// CHECK    | accepting checksum word (checksum build only)
// DONE     | load finished, done flag set
module config_loader
  import config_loader_pkg::*;
#(
  parameter int          HOLD_CYCLES = 1,
  parameter logic [31:0] IDLE_ADDR   = DEFAULT_IDLE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] writes_done
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHECK;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cfg_addr_q, cfg_addr_d;
  logic [31:0] cfg_data_q, cfg_data_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [3:0]  hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        xfer;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic        acc_clr, acc_en;
  logic [31:0] acc;

  always_comb begin
    acc_clr = start && (state_q == IDLE || state_q == DONE);
    acc_en  = xfer && (state_q == HEADER || state_q == GET_ADDR || state_q == GET_DATA);
  end

  config_xor_accum u_xor (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (in_data),
    .acc   (acc)
  );
`endif

  // State and datapath registers; bus returns to the idle address on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cfg_addr_q <= IDLE_ADDR;
      cfg_data_q <= '0;
      rem_q      <= '0;
      wcnt_q     <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      rem_q      <= rem_d;
      wcnt_q     <= wcnt_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state and datapath updates for the stream parser and write sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    rem_d      = rem_q;
    wcnt_d     = wcnt_q;
    hold_d     = hold_q;
    done_d     = done_q;
    error_d    = error_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HEADER;
          done_d  = 1'b0;
          error_d = 1'b0;
          wcnt_d  = '0;
        end
      end
      HEADER: begin
        if (xfer) begin
          rem_d   = in_data[15:0];
          state_d = (in_data[15:0] == 16'd0) ? END_STATE : GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (xfer) begin
          addr_d  = in_data;
          state_d = GET_DATA;
        end
      end
      GET_DATA: begin
        if (xfer) begin
          if (addr_q == IDLE_ADDR) begin
            // A write to the idle address would be invisible to tiles; flag and drop it.
            error_d = 1'b1;
            rem_d   = rem_q - 16'd1;
            state_d = (rem_q == 16'd1) ? END_STATE : GET_ADDR;
          end else begin
            cfg_addr_d = addr_q;
            cfg_data_d = in_data;
            hold_d     = HOLD_LOAD;
            state_d    = WRITE;
          end
        end
      end
      WRITE: begin
        if (hold_q == 4'd0) begin
          cfg_addr_d = IDLE_ADDR;
          cfg_data_d = '0;
          wcnt_d     = sat_inc16(wcnt_q);
          rem_d      = rem_q - 16'd1;
          state_d    = (rem_q == 16'd1) ? END_STATE : GET_ADDR;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (in_data != acc) error_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) done_d = 1'b1;
  end

  // Outputs decoded from registered state and flags.
  always_comb begin
    xfer        = in_valid && in_ready;
    in_ready    = (state_q == HEADER) || (state_q == GET_ADDR) ||
                  (state_q == GET_DATA) || (state_q == CHECK);
    busy        = (state_q != IDLE) && (state_q != DONE);
    done        = done_q;
    error       = error_q;
    writes_done = wcnt_q;
    config_addr = cfg_addr_q;
    config_data = cfg_data_q;
  end

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench: two loader instances (HOLD_CYCLES 1 and 3) driven independently.
// Expected writes are queued at stimulus time; a negedge monitor pops and checks them.
module tb_config_loader;

  localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        st[2];
  logic        iv[2];
  logic        rdy[2];
  logic        bsy[2];
  logic        dn[2];
  logic        er[2];
  logic [31:0] idt[2];
  logic [31:0] ca[2];
  logic [31:0] cd[2];
  logic [15:0] wd[2];

  int tests = 0;
  int fails = 0;

  logic [63:0] exq0[$];
  logic [63:0] exq1[$];
  logic [31:0] wq[$];

  int          run[2];
  logic [31:0] cura[2];
  logic [31:0] curd[2];

  always #5 clk = ~clk;

  config_loader #(.HOLD_CYCLES(1)) dut0 (
    .clk(clk), .reset(rst), .start(st[0]), .in_data(idt[0]), .in_valid(iv[0]),
    .in_ready(rdy[0]), .config_addr(ca[0]), .config_data(cd[0]), .busy(bsy[0]),
    .done(dn[0]), .error(er[0]), .writes_done(wd[0])
  );

  config_loader #(.HOLD_CYCLES(3)) dut1 (
    .clk(clk), .reset(rst), .start(st[1]), .in_data(idt[1]), .in_valid(iv[1]),
    .in_ready(rdy[1]), .config_addr(ca[1]), .config_data(cd[1]), .busy(bsy[1]),
    .done(dn[1]), .error(er[1]), .writes_done(wd[1])
  );

  function automatic int hold_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_w(input int k, input logic [31:0] a, input logic [31:0] d);
    if (k == 0) exq0.push_back({a, d});
    else        exq1.push_back({a, d});
  endtask

  // Monitor: every visible write is matched against the scoreboard and its hold length checked.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run[k] = 0;
      end else if (ca[k] !== IDLE_A) begin
        if (run[k] == 0) begin
          logic [63:0] e;
          e = {IDLE_A, 32'h0};
          if (k == 0 && exq0.size() > 0) e = exq0.pop_front();
          if (k == 1 && exq1.size() > 0) e = exq1.pop_front();
          check("write_addr", ca[k], e[63:32]);
          check("write_data", cd[k], e[31:0]);
          check("ready_in_write", {31'b0, rdy[k]}, 32'd0);
          cura[k] = ca[k];
          curd[k] = cd[k];
        end else begin
          check("hold_addr", ca[k], cura[k]);
          check("hold_data", cd[k], curd[k]);
        end
        run[k]++;
      end else if (run[k] != 0) begin
        check("hold_len", run[k], hold_of(k));
        run[k] = 0;
      end
    end
  end

  task automatic start_pulse(input int k);
    @(negedge clk); st[k] = 1'b1;
    @(negedge clk); st[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [31:0] w, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    iv[k]  = 1'b1;
    idt[k] = w;
    while (!rdy[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  // Sends wq as a full load; mid_start pulses start before word mid_start; bad_ck corrupts checksum.
  task automatic load(input int k, input bit gaps, input int mid_start, input bit bad_ck);
    logic [31:0] x;
    x = '0;
    start_pulse(k);
    for (int i = 0; i < wq.size(); i++) begin
      if (i == mid_start) start_pulse(k);
      x ^= wq[i];
      send(k, wq[i], gaps ? int'($urandom_range(0, 3)) : 0);
    end
`ifdef CONFIG_LOADER_CHECKSUM_EN
    send(k, bad_ck ? (x ^ 32'h1) : x, 0);
`else
    if (bad_ck) x = '0;
`endif
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!dn[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, dn[k]}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; iv[k] = 1'b0; idt[k] = '0; run[k] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_addr", ca[0], IDLE_A);
    check("rst_data", cd[0], 32'd0);
    check("rst_ready", {31'b0, rdy[0]}, 32'd0);
    check("rst_busy", {31'b0, bsy[0]}, 32'd0);
    check("rst_done", {31'b0, dn[0]}, 32'd0);
    check("rst_error", {31'b0, er[0]}, 32'd0);
    check("rst_wcnt", {16'b0, wd[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, default hold.
    expect_w(0, 32'h0004_0003, 32'h2);
    wq = {32'd1, 32'h0004_0003, 32'h2};
    load(0, 1'b0, -1, 1'b0);
    wait_done(0);
    check("t1_wcnt", {16'b0, wd[0]}, 32'd1);
    check("t1_error", {31'b0, er[0]}, 32'd0);
    check("t1_addr_idle", ca[0], IDLE_A);

    // Two writes held 3 cycles each.
    expect_w(1, 32'h0006_0001, 32'hA5A5_0001);
    expect_w(1, 32'h0007_0001, 32'hA5A5_0002);
    wq = {32'd2, 32'h0006_0001, 32'hA5A5_0001, 32'h0007_0001, 32'hA5A5_0002};
    load(1, 1'b0, -1, 1'b0);
    wait_done(1);
    check("t2_wcnt", {16'b0, wd[1]}, 32'd2);
    check("t2_error", {31'b0, er[1]}, 32'd0);

    // Four pairs with random valid gaps: same write sequence expected.
    wq = {32'h1234_0004, 32'h0004_0010, 32'h10, 32'h0005_0020, 32'h20,
          32'h0006_0030, 32'h30, 32'h0007_0040, 32'h40};
    expect_w(0, 32'h0004_0010, 32'h10);
    expect_w(0, 32'h0005_0020, 32'h20);
    expect_w(0, 32'h0006_0030, 32'h30);
    expect_w(0, 32'h0007_0040, 32'h40);
    load(0, 1'b1, -1, 1'b0);
    wait_done(0);
    check("t3_wcnt", {16'b0, wd[0]}, 32'd4);

    // N = 0: done one cycle after the header, no write.
    wq = {32'd0};
    load(0, 1'b0, -1, 1'b0);
`ifndef CONFIG_LOADER_CHECKSUM_EN
    check("t4_done_1cyc", {31'b0, dn[0]}, 32'd1);
    check("t4_busy", {31'b0, bsy[0]}, 32'd0);
`endif
    wait_done(0);
    check("t4_wcnt", {16'b0, wd[0]}, 32'd0);
    check("t4_error", {31'b0, er[0]}, 32'd0);

    // Idle-address pair skipped with error; start mid-load ignored.
    wq = {32'd3, 32'h0004_0010, 32'h11, IDLE_A, 32'h22, 32'h0005_0020, 32'h33};
    expect_w(1, 32'h0004_0010, 32'h11);
    expect_w(1, 32'h0005_0020, 32'h33);
    load(1, 1'b0, 3, 1'b0);
    wait_done(1);
    check("t5_error", {31'b0, er[1]}, 32'd1);
    check("t5_wcnt", {16'b0, wd[1]}, 32'd2);

    // Reset in the middle of a held write.
    expect_w(1, 32'h0004_00AA, 32'hBEEF);
    start_pulse(1);
    send(1, 32'd1, 0);
    send(1, 32'h0004_00AA, 0);
    send(1, 32'hBEEF, 0);
    check("t6_in_write", {31'b0, ca[1] !== IDLE_A}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_addr_rst", ca[1], IDLE_A);
    check("t6_busy_rst", {31'b0, bsy[1]}, 32'd0);
    check("t6_done_rst", {31'b0, dn[1]}, 32'd0);
    check("t6_err_rst", {31'b0, er[1]}, 32'd0);
    check("t6_wcnt_rst", {16'b0, wd[1]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    // Wrong checksum word flags an error but still completes.
    expect_w(0, 32'h0007_0005, 32'h55);
    wq = {32'd1, 32'h0007_0005, 32'h55};
    load(0, 1'b0, -1, 1'b1);
    wait_done(0);
    check("t6_ck_error", {31'b0, er[0]}, 32'd1);
    check("t6_ck_done", {31'b0, dn[0]}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty0", exq0.size(), 32'd0);
    check("sb_empty1", exq1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
